frame_arbiter: RTL

- Shares one downstream valid/sop/eop frame channel between NUM_REQ upstream frame sources.
- Grants are round-robin and made only at frame boundaries, so frames are never interleaved on the output.
- Enforces frame well-formedness: orphan beats, a missing eop and overlong frames are handled deterministically and reported.
- Sits in front of the frame block, so everything reaching that block is already well-formed.

---
 rtl/frame_pkg.sv | 24 ++
 rtl/frame_rr_pick.sv | 35 +++
 rtl/frame_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame arbiter slice.
package frame_pkg;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrOrphan   = 2'd1,
    ErrEarlySop = 2'd2,
    ErrOverlen  = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } arb_state_t;

  // Width of a requester index; never zero so a 1-requester build still elaborates.
  function automatic int unsigned grant_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int unsigned GRANT_W = grant_width(4);

endpackage

// File: rtl/frame_rr_pick.sv
// Combinational round-robin picker: first request strictly after the last grant, cyclic.
module frame_rr_pick
  import frame_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [grant_width(NUM_REQ)-1:0] last_i,
  output logic [NUM_REQ-1:0]              win_oh_o,
  output logic [grant_width(NUM_REQ)-1:0] win_idx_o,
  output logic                            any_o
);

  localparam int unsigned GW = grant_width(NUM_REQ);

  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = GW'((32'(last_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = idx;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/frame_arbiter.sv
// Frame-boundary round-robin arbiter that also repairs malformed frames
// (orphan beats, missing eop, overlong frames) and reports each repair.
module frame_arbiter
  import frame_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_FRAME_LEN = 256
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic [NUM_REQ-1:0]              i_valid,
  input  logic [NUM_REQ-1:0]              i_sop,
  input  logic [NUM_REQ-1:0]              i_eop,
  output logic [NUM_REQ-1:0]              o_ready,
  output logic                            o_valid,
  output logic                            o_sop,
  output logic                            o_eop,
  output logic [grant_width(NUM_REQ)-1:0] o_grant,
  output logic                            o_busy,
  output logic                            o_err,
  output logic [1:0]                      o_errCode
);

  localparam int unsigned GW = grant_width(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CW-1:0] LastCnt = CW'(MAX_FRAME_LEN - 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] ptr_q, ptr_d;

  logic          valid_q, sop_q, eop_q, err_q;
  logic [GW-1:0] out_grant_q;
  err_code_t     err_code_q;

  logic          fwd_valid, fwd_sop, fwd_eop;
  logic [GW-1:0] fwd_grant;
  logic          err_orphan, err_early, err_over;
  err_code_t     err_code_d;
  logic [NUM_REQ-1:0] ready;

  logic [NUM_REQ-1:0] pick_oh;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  frame_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i    (i_valid & i_sop),
    .last_i   (ptr_q),
    .win_oh_o (pick_oh),
    .win_idx_o(pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ready      = '0;
    fwd_valid  = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    fwd_grant  = '0;
    err_orphan = 1'b0;
    err_early  = 1'b0;
    err_over   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Orphans are swallowed in parallel with whatever grant is made.
        ready      = i_valid & ~i_sop;
        err_orphan = |(i_valid & ~i_sop);
        if (pick_any) begin
          ready     = ready | pick_oh;
          fwd_valid = 1'b1;
          fwd_sop   = 1'b1;
          fwd_eop   = i_eop[pick_idx];
          fwd_grant = pick_idx;
          if (i_eop[pick_idx]) begin
            ptr_d = pick_idx;
          end else begin
            state_d = StBusy;
            grant_d = pick_idx;
            cnt_d   = CW'(1);
          end
        end
      end

      StBusy: begin
        if (i_valid[grant_q]) begin
          fwd_valid = 1'b1;
          fwd_grant = grant_q;
          if (i_sop[grant_q]) begin
            // Close the open frame with a synthetic eop; the new sop waits for arbitration.
            fwd_eop   = 1'b1;
            err_early = 1'b1;
            state_d   = StIdle;
            ptr_d     = grant_q;
          end else begin
            ready[grant_q] = 1'b1;
            if (i_eop[grant_q]) begin
              fwd_eop = 1'b1;
              state_d = StIdle;
              ptr_d   = grant_q;
            end else if (cnt_q == LastCnt) begin
              fwd_eop  = 1'b1;
              err_over = 1'b1;
              state_d  = StDrain;
              ptr_d    = grant_q;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end

      StDrain: begin
        if (i_valid[grant_q]) begin
          if (i_sop[grant_q]) begin
            state_d = StIdle;
          end else begin
            ready[grant_q] = 1'b1;
            if (i_eop[grant_q]) state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (err_over)        err_code_d = ErrOverlen;
    else if (err_early)  err_code_d = ErrEarlySop;
    else if (err_orphan) err_code_d = ErrOrphan;
    else                 err_code_d = ErrNone;
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= GW'(NUM_REQ - 1);
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      out_grant_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      valid_q     <= fwd_valid;
      sop_q       <= fwd_sop;
      eop_q       <= fwd_eop;
      out_grant_q <= fwd_grant;
      err_q       <= err_orphan | err_early | err_over;
      err_code_q  <= err_code_d;
    end
  end

  assign o_ready   = ready;
  assign o_valid   = valid_q;
  assign o_sop     = sop_q;
  assign o_eop     = eop_q;
  assign o_grant   = out_grant_q;
  assign o_busy    = (state_q == StBusy);
  assign o_err     = err_q;
  assign o_errCode = err_code_q;

endmodule
